// File: rtl/zprize_msm_point_credit_if.sv
// Point delivery bus between the channel multiplexer, the credit stage and one MSM core.
// The master modport is the environment side (mux + core) and the slave modport is the credit stage.
interface zprize_msm_point_credit_if #(
  parameter int DATA_W     = 1152,
  parameter int CREDIT_MAX = 16
);
  localparam int CW = $clog2(CREDIT_MAX + 1);

  logic              pointPipeValid;
  logic [DATA_W-1:0] pointPipeData;
  logic              coreConsume;
  logic              creditInit;
  logic              corePointValid;
  logic [DATA_W-1:0] corePointData;
  logic              pointCreditOk;
  logic [CW-1:0]     creditCnt;
  logic              creditUnderflow;
  logic              creditOverflow;

  modport master (
    output pointPipeValid, pointPipeData, coreConsume, creditInit,
    input  corePointValid, corePointData, pointCreditOk, creditCnt,
           creditUnderflow, creditOverflow
  );

  modport slave (
    input  pointPipeValid, pointPipeData, coreConsume, creditInit,
    output corePointValid, corePointData, pointCreditOk, creditCnt,
           creditUnderflow, creditOverflow
  );
endinterface

// File: rtl/zprize_msm_point_credit.sv
// Per-core point delivery stage: fixed-latency point pipeline plus a free-slot credit
// counter that gates the upstream multiplexer through pointCreditOk.
module zprize_msm_point_credit #(
  parameter int DATA_W        = 1152,
  parameter int CREDIT_MAX    = 16,
  parameter int CREDIT_MARGIN = 4,
  parameter int PIPE_STAGES   = 2,
  localparam int CW           = $clog2(CREDIT_MAX + 1)
) (
  input  logic clk,
  input  logic rstN,
  zprize_msm_point_credit_if.slave bus
);

  localparam logic [CW-1:0] CMAX   = CW'(CREDIT_MAX);
  localparam logic [CW-1:0] MARGIN = CW'(CREDIT_MARGIN);

  // Data registers are left unreset and only load behind a valid bit.
  for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
    logic              vin;
    logic [DATA_W-1:0] din;
    logic              v_q;
    logic [DATA_W-1:0] d_q;

    if (g == 0) begin : g_first
      assign vin = bus.pointPipeValid;
      assign din = bus.pointPipeData;
    end else begin : g_next
      assign vin = g_stage[g-1].v_q;
      assign din = g_stage[g-1].d_q;
    end

    always_ff @(posedge clk) begin
      if (!rstN) v_q <= 1'b0;
      else       v_q <= vin;
    end

    always_ff @(posedge clk) begin
      if (vin) d_q <= din;
    end
  end

  assign bus.corePointValid = g_stage[PIPE_STAGES-1].v_q;
  assign bus.corePointData  = g_stage[PIPE_STAGES-1].d_q;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ok_q, ok_d;
  logic          uf_q, uf_d;
  logic          of_q, of_d;
  logic          dec, inc;

  assign dec = bus.pointPipeValid;
  assign inc = bus.coreConsume;

  // A concurrent point and consume cancel out, even at the count limits.
  always_comb begin
    cnt_d = cnt_q;
    uf_d  = uf_q;
    of_d  = of_q;
    if (bus.creditInit) begin
      cnt_d = CMAX;
      uf_d  = 1'b0;
      of_d  = 1'b0;
    end else if (dec && !inc) begin
      if (cnt_q == '0) uf_d  = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end else if (inc && !dec) begin
      if (cnt_q == CMAX) of_d  = 1'b1;
      else               cnt_d = cnt_q + 1'b1;
    end
    ok_d = (cnt_d > MARGIN);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      cnt_q <= CMAX;
      ok_q  <= 1'b1;
      uf_q  <= 1'b0;
      of_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ok_q  <= ok_d;
      uf_q  <= uf_d;
      of_q  <= of_d;
    end
  end

  assign bus.creditCnt       = cnt_q;
  assign bus.pointCreditOk   = ok_q;
  assign bus.creditUnderflow = uf_q;
  assign bus.creditOverflow  = of_q;

endmodule
